// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
// Shared types for the LED event scheduler slice.
//   cmd_t         : 2-bit command word held in the event FIFO.
//   sched_state_t : scheduler FSM state, also exported for debug.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_NEXT = 2'd1,
        CMD_PREV = 2'd2
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/led_event_scheduler_if.sv
// led_event_scheduler_if
// Groups the debouncer-side requests and cycler-side commands of the
// scheduler.
//   next_in/prev_in/rst_in    : one-shot requests from the debouncers
//   next_out/prev_out/rst_out : one-cycle, mutually exclusive commands
//   busy                      : HOLD or FIFO non-empty
//   dropped                   : one-cycle pulse, a request was lost (FIFO full)
//   level                     : FIFO occupancy
//   state                     : scheduler FSM state (debug visibility)
// Handshake: there is no back-pressure. A request is a single-cycle pulse
// that is sampled on the rising clock edge; it is either queued or
// reported through dropped one cycle later. A command is a single-cycle
// pulse that the cycler must take on that same cycle.
interface led_event_scheduler_if
    import led_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                     next_in;
    logic                     prev_in;
    logic                     rst_in;
    logic                     next_out;
    logic                     prev_out;
    logic                     rst_out;
    logic                     busy;
    logic                     dropped;
    logic [$clog2(DEPTH):0]   level;
    sched_state_t             state;

    // master: the debouncer/requester side
    modport master (
        output next_in, prev_in, rst_in,
        input  next_out, prev_out, rst_out, busy, dropped, level, state
    );

    // slave: the scheduler itself
    modport slave (
        input  next_in, prev_in, rst_in,
        output next_out, prev_out, rst_out, busy, dropped, level, state
    );
endinterface

// File: rtl/event_fifo.sv
// event_fifo
// DEPTH x 2-bit synchronous FIFO with a first-word-fall-through head.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop, dout  : read request and current head
//   flush      : empty the FIFO; wins over push and pop
//   full, empty, level : occupancy status
// A push while full is accepted only if a pop happens in the same cycle.
module event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [1:0]             din,
    output logic [1:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/led_event_scheduler.sv
// led_event_scheduler
// Queues next/prev button events and issues them to the LED cycler one at a
// time, keeping at least GAP_CYCLES idle cycles after each command. A reset
// request flushes the queue and is issued immediately.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : led_event_scheduler_if.slave (requests, commands, status, state)
module led_event_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_event_scheduler_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);

    sched_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          next_q, prev_q, rst_q, dropped_q;
    logic          next_d, prev_d, rst_d;

    logic          push_req;
    logic [1:0]    push_cmd;
    logic          fifo_push;
    logic          pop;
    logic [1:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    // A reset request discards same-cycle next/prev; a simultaneous
    // next+prev pair cancels out.
    assign push_req  = !bus.rst_in && (bus.next_in ^ bus.prev_in);
    assign push_cmd  = bus.next_in ? CMD_NEXT : CMD_PREV;
    assign fifo_push = push_req && (!fifo_full || pop);

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop),
        .flush (bus.rst_in),
        .din   (push_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        next_d  = 1'b0;
        prev_d  = 1'b0;
        rst_d   = 1'b0;
        if (bus.rst_in) begin
            // Reset bypasses the queue and restarts any gap in progress.
            rst_d   = 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        next_d  = (cmd_t'(head) == CMD_NEXT);
                        prev_d  = (cmd_t'(head) == CMD_PREV);
                        cnt_d   = GAP_LOAD;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // The pulse cycle itself counts as the first HOLD cycle,
                    // so pulses land GAP_CYCLES+2 apart when the queue is busy.
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            next_q    <= 1'b0;
            prev_q    <= 1'b0;
            rst_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            next_q    <= next_d;
            prev_q    <= prev_d;
            rst_q     <= rst_d;
            dropped_q <= push_req && fifo_full && !pop;
        end
    end

    assign bus.next_out = next_q;
    assign bus.prev_out = prev_q;
    assign bus.rst_out  = rst_q;
    assign bus.dropped  = dropped_q;
    assign bus.level    = fifo_level;
    assign bus.busy     = (state_q == HOLD) || !fifo_empty;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_led_event_scheduler.sv
// tb_led_event_scheduler
// Self-checking bench for led_event_scheduler (DEPTH=4, GAP_CYCLES=4).
// The reference model keeps the queued commands in a queue and the earliest
// cycle at which the next command may be issued.
module tb_led_event_scheduler;
    import led_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    led_event_scheduler_if #(.DEPTH(DEPTH)) bus ();

    led_event_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0] exp_q[$];     // queued commands, head first
    int         cyc;          // index of the cycle currently being driven
    int         next_ok;      // earliest cycle in which a command may issue
    logic       exp_next, exp_prev, exp_rst, exp_drop, exp_busy;

    int checks;
    int errors;

    function automatic logic [7:0] exp_vec();
        return {exp_next, exp_prev, exp_rst, exp_busy, exp_drop, LW'(exp_q.size())};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.next_out, bus.prev_out, bus.rst_out, bus.busy, bus.dropped, bus.level};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        next_ok  = 0;
        exp_next = 1'b0;
        exp_prev = 1'b0;
        exp_rst  = 1'b0;
        exp_drop = 1'b0;
        exp_busy = 1'b0;
    endtask

    // Drives one cycle of requests (called just after a falling edge), advances
    // the model and returns after the next falling edge with the expectations
    // for that new cycle.
    task automatic drive_cycle(input logic n, input logic p, input logic r);
        logic       issue;
        logic [1:0] head;
        bus.next_in = n;
        bus.prev_in = p;
        bus.rst_in  = r;
        issue    = (cyc >= next_ok) && (exp_q.size() > 0) && !r;
        exp_next = 1'b0;
        exp_prev = 1'b0;
        exp_rst  = 1'b0;
        exp_drop = 1'b0;
        if (r) begin
            exp_q.delete();
            exp_rst = 1'b1;
            next_ok = cyc + GAP + 2;
        end else begin
            if (issue) begin
                head     = exp_q.pop_front();
                exp_next = (head == CMD_NEXT);
                exp_prev = (head == CMD_PREV);
                next_ok  = cyc + GAP + 2;
            end
            if (n ^ p) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(n ? CMD_NEXT : CMD_PREV);
                else                      exp_drop = 1'b1;
            end
        end
        cyc++;
        exp_busy = (cyc < next_ok) || (exp_q.size() > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 8'h00);
        end
        checks++;
        if (bus.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE);
        end
    endtask

    task automatic test_single();
        int req_cyc;
        int pulse_cyc;
        int pulses;
        pulses    = 0;
        pulse_cyc = -1;
        req_cyc   = cyc;
        drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GAP + 6; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (bus.next_out === 1'b1) begin
                pulses++;
                pulse_cyc = cyc;
            end
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (pulses != 1 || pulse_cyc != req_cyc + 2) begin
            errors++;
            $display("FAIL single_latency pulses=%0d at=%0d exp 1 at %0d", pulses, pulse_cyc, req_cyc + 2);
        end
    endtask

    task automatic test_burst();
        int edges[$];
        int drops;
        logic last_next;
        drops     = 0;
        last_next = 1'b0;
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        // now in the first pulse cycle: five more requests while holding
        for (int i = 0; i < 45; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (bus.next_out === 1'b1 && !last_next) edges.push_back(cyc);
            if (bus.dropped === 1'b1) drops++;
            last_next = bus.next_out;
            drive_cycle(i < 5, 1'b0, 1'b0);
        end
        checks++;
        if (edges.size() != 5 || drops != 1) begin
            errors++;
            $display("FAIL burst_count pulses=%0d drops=%0d exp 5 and 1", edges.size(), drops);
        end
        for (int i = 1; i < edges.size(); i++) begin
            checks++;
            if (edges[i] - edges[i-1] != GAP + 2) begin
                errors++;
                $display("FAIL burst_spacing got=%0d exp=%0d", edges[i] - edges[i-1], GAP + 2);
            end
        end
    endtask

    task automatic test_cancel();
        drive_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_vec() !== exp_vec() || exp_vec() !== 8'h00) begin
                errors++;
                $display("FAIL cancel cyc=%0d got=%b exp=%b", cyc, dut_vec(), 8'h00);
            end
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        int queued_pulses;
        queued_pulses = 0;
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.level !== LW'(3)) begin
            errors++;
            $display("FAIL flush_prefill got=%0d exp=%0d", bus.level, 3);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < GAP + 8; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (bus.next_out === 1'b1 || bus.prev_out === 1'b1) queued_pulses++;
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (queued_pulses != 0) begin
            errors++;
            $display("FAIL flush_no_issue got=%0d exp=%0d", queued_pulses, 0);
        end
    endtask

    task automatic test_full_pushpop();
        logic n;
        drive_cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_pushpop cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            n = 1'($urandom_range(0, 1));
            drive_cycle(n, !n, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        pulses = 0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.prev_out !== 1'b1 || exp_prev !== 1'b1) begin
            errors++;
            $display("FAIL async_pre prev_out got=%b exp=%b", bus.prev_out, 1'b1);
        end
        bus.next_in = 1'b0;
        bus.prev_in = 1'b0;
        bus.rst_in  = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 8'h00 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL async_clear got=%b exp=%b", dut_vec(), 8'h00);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL async_after cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (bus.next_out === 1'b1 || bus.prev_out === 1'b1 || bus.rst_out === 1'b1) pulses++;
            drive_cycle(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL async_no_pulse got=%0d exp=%0d", pulses, 0);
        end
    endtask

    task automatic test_random();
        logic n, p, r;
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 39) == 0);
            n = ($urandom_range(0, 9) < 3);
            p = ($urandom_range(0, 9) < 3);
            drive_cycle(n, p, r);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        bus.next_in = 1'b0;
        bus.prev_in = 1'b0;
        bus.rst_in  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single();
        test_burst();
        test_cancel();
        test_flush();
        test_full_pushpop();
        test_async_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_event_scheduler.md
# led_event_scheduler

Sequences button events into the LED-cycle datapath. It sits between the three one-shot debouncers (next, prev, reset) and the LED cycler. It queues next/prev events in a small FIFO, issues at most one command pulse at a time with a programmable minimum spacing, and lets reset bypass and flush the queue. This prevents bursts or simultaneous presses from being lost or merged.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- GAP_CYCLES, 16: minimum idle cycles after each issued pulse; ≥1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- next_in  in  1  one-shot request from the next debouncer.
- prev_in  in  1  one-shot request from the prev debouncer.
- rst_in  in  1  one-shot request from the reset debouncer.
- next_out  out  1  one-cycle command to the cycler.
- prev_out  out  1  one-cycle command to the cycler.
- rst_out  out  1  one-cycle command to the cycler.
- busy  out  1  high while in HOLD or FIFO non-empty.
- dropped  out  1  one-cycle pulse when an event is discarded because the FIFO is full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Command encoding: CMD_NEXT=2'd1, CMD_PREV=2'd2; FIFO stores 2-bit commands.
- Push rules, evaluated each cycle, rst_in first:
  - rst_in=1: flush the FIFO (level→0), load rst_out for the next cycle, discard next_in/prev_in in that cycle. dropped stays 0.
  - next_in=1 and prev_in=1 together: they cancel; nothing is pushed.
  - Exactly one of next_in/prev_in: push the matching command.
- Full FIFO:
  - Push with a pop in the same cycle is accepted.
  - Push without a pop is discarded (newest lost) and dropped=1 for that cycle.
- FSM with states IDLE and HOLD:
  - IDLE, FIFO non-empty, no rst_in: pop the head and register the matching *_out for the next cycle, load the gap counter with GAP_CYCLES, go to HOLD.
  - HOLD: decrement the counter each cycle; at 0 go to IDLE. No pop in HOLD.
  - rst_in in any state: rst_out next cycle, reload the counter with GAP_CYCLES, go to HOLD. This aborts any gap in progress.
- Outputs next_out, prev_out and rst_out are registered and mutually exclusive; each is high for exactly one cycle per command.
- Gap counter width is $clog2(GAP_CYCLES+1). It never underflows.
- Reset values: every output 0, level=0, FIFO empty, state IDLE, counter 0.

## Timing
- Queued event latency, from FIFO empty and IDLE:
  - Request high in cycle t.
  - Pop in t+1.
  - *_out high in cycle t+2.
- rst_in high in cycle t → rst_out high in cycle t+1.
- Spacing between consecutive output pulses (rising edge to rising edge) is ≥ GAP_CYCLES+2 cycles.
  - Exactly GAP_CYCLES+2 when the FIFO is continuously non-empty.
- level updates the cycle after a push or pop.
- Simultaneous push and pop leaves level unchanged.
- busy is combinational from state and level.
- dropped is registered, so it is high in cycle t+1 for a discarded request in cycle t.
- rst_n asserted mid-pulse clears the outputs immediately (asynchronously). After deassertion the first command can issue no earlier than the first clock edge.

## Structure
- Package led_ctrl_pkg holds:
  - cmd_t (CMD_NONE, CMD_NEXT, CMD_PREV).
  - sched_state_t (IDLE, HOLD).
- Sub-module event_fifo:
  - DEPTH×2-bit synchronous FIFO.
  - Ports: push, pop, flush, din, dout, full, empty, level.
  - Pointer wrap at DEPTH.
  - Flush takes priority over push and pop.
- led_event_scheduler contains the push logic, the FSM, the gap counter and the output registers.

## Test plan
- Single next_in at t=5, DEPTH=4, GAP_CYCLES=4 → next_out high only at t=7; level 1 at t=6, 0 at t=7.
- Five next_in pulses at t=10..14 during HOLD:
  - Four are queued; dropped high at t=15.
  - next_out fires four times with rising edges exactly 6 cycles apart.
- next_in and prev_in together at t=20 with FIFO empty → no push, no output, level stays 0, dropped=0.
- FIFO holds 3 entries in HOLD, rst_in at t=30 → level 0 at t=31, rst_out at t=31 only, then HOLD for 4 cycles, no queued command issued.
- Full FIFO in IDLE with push at the pop cycle → push accepted, level stays 4, dropped=0.
- rst_n low for 2 cycles mid-HOLD with prev_out just asserted → all outputs 0 immediately; after release no pulse until a new request arrives.
